line_refill_engine: RTL
=======================

LINE_REFILL_ENGINE -- requirements
Module: line_refill_engine

Interface
- REQ-001 Parameter LINE_WORDS, default 4, words per cache line, power of two, 2..16.
- REQ-002 Parameter TIMEOUT_CYCLES, default 64, max cycles from word request to data_res.
- REQ-003 mem_clk  in  1  sole clock; all state changes on its rising edge.
- REQ-004 rst  in  1  reset, synchronous and active-high.
- REQ-005 line_req  in  1  L2 line transfer request; sampled only in IDLE.
- REQ-006 line_write  in  1  1 = write back line, 0 = refill line; sampled with line_req.
- REQ-007 line_addr  in  32  line address; bits below line alignment ignored.
- REQ-008 line_wdata  in  32*LINE_WORDS  write-back data, word 0 in LSBs; sampled with line_req.
- REQ-009 line_rdata  out  32*LINE_WORDS  refilled line, word 0 in LSBs.
- REQ-010 line_ack  out  1  one-cycle pulse when the transfer ends.
- REQ-011 line_err  out  1  valid with line_ack; 1 = transfer aborted on timeout.
- REQ-012 busy  out  1  high in every state except IDLE.
- REQ-013 data_addr  out  32  word address to memory.
- REQ-014 data_mem_write  out  32  write word to memory.
- REQ-015 data_read_req / data_write_req  out  1 each  level requests to memory; never both high.
- REQ-016 data_mem_read  in  32  read word from memory, valid while data_res is high.
- REQ-017 data_res  in  1  memory response pulse.

Function
- REQ-018 FSM states: IDLE, REQ, GAP, DONE, plus ERR when timeout is compiled in.
- REQ-019 IDLE with line_req=1: latch line_addr, line_write and line_wdata; clear word counter; go to REQ.
- REQ-020 In REQ, drive the selected request high; data_addr = {line base, counter, 2'b00}; data_mem_write = latched word[counter].
- REQ-021 data_addr and data_mem_write stay stable for the whole REQ state.
- REQ-022 REQ with data_res=1: for reads, store data_mem_read into line_rdata word[counter].
- REQ-023 REQ with data_res=1: drop the request; if counter = LINE_WORDS-1 go to DONE, else increment counter and go to GAP.
- REQ-024 GAP lasts exactly one cycle with both requests low, then returns to REQ; this guarantees the rising edge the memory detects.
- REQ-025 DONE lasts one cycle with line_ack=1 and line_err=0, then goes to IDLE.
- REQ-026 Counter covers only the in-line word bits; it never carries into the line base, so a line at 0xFFFF_FFF0 stays in place.
- REQ-027 data_res in IDLE, GAP or DONE is ignored.
- REQ-028 line_req while busy is ignored and not queued.
- REQ-029 line_rdata holds its last value until the next refill overwrites it word by word; a write-back leaves it unchanged.
- REQ-030 Latency with the 2-cycle memory: data_res is seen 3 cycles after the request rises.
  - Per word: 4 cycles.
  - With acceptance at edge A, line_ack is high in the cycle starting at edge A+4*LINE_WORDS-1.

Reset
- REQ-031 While rst=1 at a clock edge, the state goes to IDLE and the counter to 0.
- REQ-032 During reset, data_read_req, data_write_req, line_ack, line_err and busy are driven to 0; data_addr, data_mem_write and line_rdata are cleared to 0.
- REQ-033 Reset mid-transfer drops the request on the next edge with no line_ack; a late data_res is ignored.

Configuration
- REQ-034 Macro RVS192_MEM_TIMEOUT_EN compiles the watchdog in.
- REQ-035 With the macro defined:
  - The watchdog counter clears on entering REQ and counts each REQ cycle without data_res.
  - When it reaches TIMEOUT_CYCLES, the engine drops the request and goes to ERR.
  - ERR lasts one cycle with line_ack=1 and line_err=1, then goes to IDLE.
- REQ-036 Without the macro: ERR and the watchdog counter do not exist, line_err is tied to 0, and REQ waits indefinitely.

Verification
- REQ-037 Refill, memory preloaded 0x400..0x40C = 1,2,3,4; line_req, addr 0x404 -> data_addr sequence 0x400, 0x404, 0x408, 0x40C; line_rdata = {4,3,2,1}; one line_ack with line_err=0 at A+15.
- REQ-038 Write-back of {0xD,0xC,0xB,0xA} to 0x800 -> memory 0x800..0x80C = 0xA,0xB,0xC,0xD; data_read_req never high; line_ack at A+15.
- REQ-039 Between consecutive words, both requests are low for exactly 1 cycle; the memory model registers 4 rising-edge samples per line.
- REQ-040 line_req pulsed at cycles 5 and 9 after acceptance -> ignored; exactly one line_ack.
- REQ-041 rst asserted 6 cycles into a refill -> requests low and busy=0 next cycle; no line_ack; a new refill then completes correctly.
- REQ-042 With RVS192_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, data_res tied low -> request drops 8 cycles after rising; line_ack=1 and line_err=1 in the next cycle.

Source files
------------

// File: rtl/line_refill_engine_if.sv
// ----------------------------------------------------------------------------
// line_refill_engine_if
//   Bundles the L2 line-transfer handshake and the word-wide memory bus seen
//   by line_refill_engine.
//   slave  : the engine side. It accepts line requests and issues word requests.
//   master : the environment side. This is the L2 requester plus the memory.
//   Line side  : line_req, line_write, line_addr, line_wdata -> engine
//                line_rdata, line_ack, line_err, busy       <- engine
//   Memory side: data_addr, data_mem_write, data_read_req,
//                data_write_req                             <- engine
//                data_mem_read, data_res                    -> engine
// ----------------------------------------------------------------------------
interface line_refill_engine_if #(
    parameter int LINE_WORDS = 4
);
    logic                       line_req;
    logic                       line_write;
    logic [31:0]                line_addr;
    logic [32*LINE_WORDS-1:0]   line_wdata;
    logic [32*LINE_WORDS-1:0]   line_rdata;
    logic                       line_ack;
    logic                       line_err;
    logic                       busy;
    logic [31:0]                data_addr;
    logic [31:0]                data_mem_write;
    logic                       data_read_req;
    logic                       data_write_req;
    logic [31:0]                data_mem_read;
    logic                       data_res;

    modport slave (
        input  line_req, line_write, line_addr, line_wdata, data_mem_read, data_res,
        output line_rdata, line_ack, line_err, busy,
               data_addr, data_mem_write, data_read_req, data_write_req
    );

    modport master (
        output line_req, line_write, line_addr, line_wdata, data_mem_read, data_res,
        input  line_rdata, line_ack, line_err, busy,
               data_addr, data_mem_write, data_read_req, data_write_req
    );
endinterface

// File: rtl/line_refill_engine.sv
// ----------------------------------------------------------------------------
// line_refill_engine
//   Moves one cache line between L2 and a word-wide memory. The line is moved
//   one word at a time using level requests. A write-back sends the latched
//   line out. A refill fills line_rdata word by word.
//   Each word request is followed by a one-cycle gap with both requests low,
//   so the memory always sees a fresh rising edge.
//   Ports:
//     mem_clk : sole clock, rising edge
//     rst     : synchronous, active-high reset
//     bus     : line_refill_engine_if.slave (line handshake + memory bus)
//   Parameters:
//     LINE_WORDS     : words per line, power of two, 2..16
//     TIMEOUT_CYCLES : watchdog limit on one word request
//   Optional feature:
//     RVS192_MEM_TIMEOUT_EN : compiles in the watchdog and the ERR state.
//     Without it, line_err is tied to 0 and a word request waits forever.
// ----------------------------------------------------------------------------
module line_refill_engine #(
    parameter int LINE_WORDS     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  mem_clk,
    input  logic                  rst,
    line_refill_engine_if.slave   bus
);
    localparam int CW = $clog2(LINE_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        GAP,
        DONE
`ifdef RVS192_MEM_TIMEOUT_EN
        , ERR
`endif
    } state_t;

    state_t                       state_q, state_d;
    logic [CW-1:0]                cnt_q;
    logic [29-CW:0]               base_q;
    logic                         wr_q;
    logic [LINE_WORDS-1:0][31:0]  wdata_q;
    logic [LINE_WORDS-1:0][31:0]  rdata_q;
    logic                         last_word;
    logic                         timeout;
    logic                         rd_req, wr_req, ack, err;

    // The offset bits of line_addr are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.line_addr[CW+1:0];

    assign last_word = (cnt_q == CW'(LINE_WORDS-1));

`ifdef RVS192_MEM_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES+1);
    logic [WDW-1:0] wd_q;

    // wd_q counts the REQ cycles that have already gone by without a
    // response. Timing out when the current cycle would be number
    // TIMEOUT_CYCLES drops the request exactly TIMEOUT_CYCLES cycles after
    // it rose.
    assign timeout = (wd_q == WDW'(TIMEOUT_CYCLES-1)) && !bus.data_res;

    always_ff @(posedge mem_clk) begin
        if (rst)
            wd_q <= '0;
        else if (state_d == REQ && state_q != REQ)
            wd_q <= '0;
        else if (state_q == REQ && !bus.data_res)
            wd_q <= wd_q + WDW'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge mem_clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        ack     = 1'b0;
        err     = 1'b0;
        case (state_q)
            IDLE: if (bus.line_req) state_d = REQ;
            REQ: begin
                rd_req = !wr_q;
                wr_req = wr_q;
                if (bus.data_res)
                    state_d = last_word ? DONE : GAP;
`ifdef RVS192_MEM_TIMEOUT_EN
                else if (timeout)
                    state_d = ERR;
`endif
            end
            GAP:  state_d = REQ;
            DONE: begin
                ack     = 1'b1;
                state_d = IDLE;
            end
`ifdef RVS192_MEM_TIMEOUT_EN
            ERR: begin
                ack     = 1'b1;
                err     = 1'b1;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Datapath. The counter is only CW bits wide, so it can never carry into
    // the line base.
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            cnt_q   <= '0;
            base_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.line_req) begin
                    base_q  <= bus.line_addr[31:CW+2];
                    wr_q    <= bus.line_write;
                    wdata_q <= bus.line_wdata;
                    cnt_q   <= '0;
                end
                REQ: if (bus.data_res) begin
                    if (!wr_q)      rdata_q[cnt_q] <= bus.data_mem_read;
                    if (!last_word) cnt_q <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Address and write data come straight from registers. They hold steady
    // for the whole REQ state and read as 0 after reset.
    assign bus.data_addr      = {base_q, cnt_q, 2'b00};
    assign bus.data_mem_write = wdata_q[cnt_q];
    assign bus.data_read_req  = rd_req;
    assign bus.data_write_req = wr_req;
    assign bus.line_rdata     = rdata_q;
    assign bus.line_ack       = ack;
    assign bus.line_err       = err;
    assign bus.busy           = (state_q != IDLE);
endmodule
